// File: rtl/uriscv_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uriscv_irq_ctrl_pkg
// Shared definitions for the external interrupt controller:
//   - register byte offsets (bits [1:0] of the bus address are ignored)
//   - FSM state encoding
//   - the "no source" claim ID
// ---------------------------------------------------------------------------
package uriscv_irq_ctrl_pkg;

  localparam logic [7:0] IRQC_PENDING  = 8'h00;
  localparam logic [7:0] IRQC_ENABLE   = 8'h04;
  localparam logic [7:0] IRQC_EDGE_SEL = 8'h08;
  localparam logic [7:0] IRQC_CLAIM    = 8'h0C;
  localparam logic [7:0] IRQC_STATUS   = 8'h10;

  localparam logic [4:0] IRQC_ID_NONE  = 5'd0;

  typedef enum logic {
    IRQC_STATE_IDLE    = 1'b0,
    IRQC_STATE_SERVICE = 1'b1
  } irqc_state_e;

endpackage

// File: rtl/uriscv_irq_sync.sv
// ---------------------------------------------------------------------------
// uriscv_irq_sync
// Synchroniser for one asynchronous, active-high interrupt line.
//   SYNC_STAGES flops bring irq_i into the clk_i domain; one further delay
//   flop lets a rising edge be detected on the synchronised level.
// Ports:
//   clk_i    in  core clock
//   rst_i    in  synchronous active-high reset
//   irq_i    in  asynchronous device line
//   level_o  out synchronised level
//   rise_o   out one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module uriscv_irq_sync
  import uriscv_irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   delay_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg  <= '0;
      delay_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], irq_i};
      delay_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_reg[SYNC_STAGES-1];
  assign rise_o  = sync_reg[SYNC_STAGES-1] & ~delay_reg;

endmodule

// File: rtl/uriscv_irq_ctrl.sv
// ---------------------------------------------------------------------------
// uriscv_irq_ctrl
// Memory-mapped external interrupt controller feeding the CSR unit's intr_i.
// Each source is synchronised, latched as level or rising-edge pending,
// masked by ENABLE and priority-encoded (lowest index wins, ID = index+1).
// Software claims the source with a CLAIM read and completes service by
// writing the same ID back to CLAIM.
// Ports:
//   clk_i    in  core clock
//   rst_i    in  synchronous active-high reset
//   req_i    in  one-cycle register access request
//   we_i     in  1 = write, 0 = read
//   addr_i   in  byte offset, bits [1:0] ignored
//   wdata_i  in  write data
//   rdata_o  out read data, valid with ack_o
//   ack_o    out access done, one cycle after req_i
//   irq_i    in  asynchronous active-high device lines
//   intr_o   out registered machine-external interrupt request
// ---------------------------------------------------------------------------
module uriscv_irq_ctrl
  import uriscv_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               intr_o
);

  // Synchronised inputs
  logic [NUM_IRQ-1:0] level;
  logic [NUM_IRQ-1:0] rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
      uriscv_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .irq_i   (irq_i[gi]),
        .level_o (level[gi]),
        .rise_o  (rise[gi])
      );
    end
  endgenerate

  // Architectural state
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] enable_reg;
  logic [NUM_IRQ-1:0] edge_sel_reg;
  irqc_state_e        state_reg;
  logic [4:0]         claim_id_reg;
  logic               intr_reg;
  logic               ack_reg;
  logic [31:0]        rdata_reg;
  logic [31:0]        rdata_next;

  // Bus decode
  logic [7:0] reg_addr;
  logic       addr_unused;
  logic       wr_access;
  logic       rd_access;

  assign reg_addr    = {addr_i[7:2], 2'b00};
  assign addr_unused = ^addr_i[1:0];
  assign wr_access   = req_i & we_i;
  assign rd_access   = req_i & ~we_i;

  // Priority encoder over pending & enabled sources
  logic [NUM_IRQ-1:0] active;
  logic [4:0]         best_id;
  logic [NUM_IRQ-1:0] best_mask;

  assign active = pending_reg & enable_reg;

  always_comb begin
    best_id   = IRQC_ID_NONE;
    best_mask = '0;
    // Walk from the top down so the lowest index overwrites last.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        best_id      = 5'(i + 1);
        best_mask    = '0;
        best_mask[i] = 1'b1;
      end
    end
  end

  // Claim / complete qualification
  logic claim_take;
  logic complete;

  assign claim_take = rd_access && (reg_addr == IRQC_CLAIM) &&
                      (state_reg == IRQC_STATE_IDLE) && (best_id != IRQC_ID_NONE);
  assign complete   = wr_access && (reg_addr == IRQC_CLAIM) &&
                      (state_reg == IRQC_STATE_SERVICE) &&
                      (wdata_i == {27'b0, claim_id_reg});

  // Pending update. Edge sources: a new rise always wins over a clear
  // (W1C or claim) in the same cycle. Level sources simply track the
  // synchronised line, so W1C has no lasting effect on them.
  logic [NUM_IRQ-1:0] edge_clr;

  always_comb begin
    edge_clr = '0;
    if (wr_access && (reg_addr == IRQC_PENDING)) begin
      edge_clr = wdata_i[NUM_IRQ-1:0];
    end
    if (claim_take) begin
      edge_clr = edge_clr | best_mask;
    end
  end

  assign pending_next = (edge_sel_reg & (rise | (pending_reg & ~edge_clr))) |
                        (~edge_sel_reg & level);

  // Read mux
  always_comb begin
    rdata_next = '0;
    case (reg_addr)
      IRQC_PENDING:  rdata_next[NUM_IRQ-1:0] = pending_reg;
      IRQC_ENABLE:   rdata_next[NUM_IRQ-1:0] = enable_reg;
      IRQC_EDGE_SEL: rdata_next[NUM_IRQ-1:0] = edge_sel_reg;
      IRQC_CLAIM:    rdata_next[4:0] = (state_reg == IRQC_STATE_SERVICE) ?
                                       claim_id_reg : best_id;
      IRQC_STATUS:   rdata_next = {(state_reg == IRQC_STATE_SERVICE), 26'b0, claim_id_reg};
      default:       rdata_next = '0;
    endcase
  end

  // Registers and FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg  <= '0;
      enable_reg   <= '0;
      edge_sel_reg <= '0;
      state_reg    <= IRQC_STATE_IDLE;
      claim_id_reg <= IRQC_ID_NONE;
      intr_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      ack_reg     <= req_i;
      rdata_reg   <= rd_access ? rdata_next : 32'h0;
      pending_reg <= pending_next;

      if (wr_access && (reg_addr == IRQC_ENABLE)) begin
        enable_reg <= wdata_i[NUM_IRQ-1:0];
      end
      if (wr_access && (reg_addr == IRQC_EDGE_SEL)) begin
        edge_sel_reg <= wdata_i[NUM_IRQ-1:0];
      end

      case (state_reg)
        IRQC_STATE_IDLE: begin
          intr_reg <= |active;
          if (claim_take) begin
            state_reg    <= IRQC_STATE_SERVICE;
            claim_id_reg <= best_id;
          end
        end
        IRQC_STATE_SERVICE: begin
          // No nesting: the request stays low until service completes.
          intr_reg <= 1'b0;
          if (complete) begin
            state_reg    <= IRQC_STATE_IDLE;
            claim_id_reg <= IRQC_ID_NONE;
          end
        end
        default: begin
          state_reg    <= IRQC_STATE_IDLE;
          claim_id_reg <= IRQC_ID_NONE;
          intr_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o = rdata_reg;
  assign ack_o   = ack_reg;
  assign intr_o  = intr_reg;

endmodule
